// File: rtl/stream_sender.sv
// Burst issue stage feeding the ring-buffer stage; stalls on Nack, resumes after a clean gap.
// Optional stall-cycle counter: define STREAM_SENDER_STALL_CNT_EN.
package stream_sender_pkg;

    typedef struct packed {
        logic        v;
        logic [31:0] d;
    } FTk_t;

    typedef struct packed {
        logic n;
    } BTk_t;

endpackage

module stream_sender
    import stream_sender_pkg::*;
#(
    parameter int WIDTH_LEN  = 16,
    parameter int RESUME_GAP = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 I_Start,
    input  logic [WIDTH_LEN-1:0] I_Len,
    input  logic                 I_Src_Valid,
    input  FTk_t                 I_Src_FTk,
    output logic                 O_Src_Rd,
    output FTk_t                 O_FTk,
    input  BTk_t                 I_BTk,
    output logic                 O_Last,
    output logic                 O_Busy,
    output logic                 O_Done,
    output logic [WIDTH_LEN-1:0] O_Sent,
    output logic [31:0]          O_Stall_Cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STALL,
        DONE
    } state_t;

    localparam logic [2:0]           GAP_END = 3'(RESUME_GAP - 1);
    localparam logic [WIDTH_LEN-1:0] ONE     = WIDTH_LEN'(1);

    state_t               state;
    logic [WIDTH_LEN-1:0] r_rem;
    logic [2:0]           gap;
    logic                 send;

    // Nack gates the launch combinationally so no token leaves while it is high
    assign send     = (state == RUN) & I_Src_Valid & ~I_BTk.n;
    assign O_Src_Rd = send;
    assign O_Busy   = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            r_rem  <= '0;
            gap    <= '0;
            O_FTk  <= '0;
            O_Last <= 1'b0;
            O_Done <= 1'b0;
            O_Sent <= '0;
        end else begin
            O_FTk  <= '0;
            O_Last <= 1'b0;
            O_Done <= 1'b0;
            if (send) begin
                O_FTk   <= I_Src_FTk;
                O_FTk.v <= 1'b1;
                O_Last  <= (r_rem == ONE);
            end
            unique case (state)
                IDLE: begin
                    if (I_Start) begin
                        O_Sent <= '0;
                        r_rem  <= I_Len;
                        state  <= (I_Len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (I_BTk.n) begin
                        state <= STALL;
                        gap   <= '0;
                    end else if (I_Src_Valid) begin
                        r_rem <= r_rem - ONE;
                        if (O_Sent != '1)
                            O_Sent <= O_Sent + ONE;
                        if (r_rem == ONE)
                            state <= DONE;
                    end
                end
                STALL: begin
                    if (I_BTk.n) begin
                        gap <= '0;
                    end else if (gap == GAP_END) begin
                        gap   <= '0;
                        state <= RUN;
                    end else begin
                        gap <= gap + 3'd1;
                    end
                end
                DONE: begin
                    O_Done <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STREAM_SENDER_STALL_CNT_EN
    logic [31:0] stall_cnt;

    // The RUN cycle that sees Nack already blocks issue, so it counts as stalled
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (state == IDLE && I_Start) begin
            stall_cnt <= '0;
        end else if ((state == STALL || (state == RUN && I_BTk.n))
                     && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign O_Stall_Cnt = stall_cnt;
`else
    assign O_Stall_Cnt = 32'h0;
`endif

endmodule

// File: tb/tb_stream_sender.sv
// Testbench for stream_sender: vector table of bursts plus a reset-abort sequence.
// Tokens are checked in order through an expected-token queue.
module tb_stream_sender;
    import stream_sender_pkg::*;

    localparam int WL   = 16;
    localparam int NCYC = 20;

    logic          clock = 1'b0;
    logic          reset;
    logic          I_Start;
    logic [WL-1:0] I_Len;
    logic          I_Src_Valid;
    FTk_t          I_Src_FTk;
    logic          O_Src_Rd;
    FTk_t          O_FTk;
    BTk_t          I_BTk;
    logic          O_Last;
    logic          O_Busy;
    logic          O_Done;
    logic [WL-1:0] O_Sent;
    logic [31:0]   O_Stall_Cnt;

    stream_sender #(.WIDTH_LEN(WL), .RESUME_GAP(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .I_Start     (I_Start),
        .I_Len       (I_Len),
        .I_Src_Valid (I_Src_Valid),
        .I_Src_FTk   (I_Src_FTk),
        .O_Src_Rd    (O_Src_Rd),
        .O_FTk       (O_FTk),
        .I_BTk       (I_BTk),
        .O_Last      (O_Last),
        .O_Busy      (O_Busy),
        .O_Done      (O_Done),
        .O_Sent      (O_Sent),
        .O_Stall_Cnt (O_Stall_Cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        string         name;
        logic [WL-1:0] len;
        logic [31:0]   start_m;
        logic [31:0]   valid_m;
        logic [31:0]   nack_m;
        logic [31:0]   exp_rd;
        logic [31:0]   exp_last;
        logic [31:0]   exp_done;
        logic [WL-1:0] exp_sent;
        logic [31:0]   exp_stall;
    } vec_t;

    vec_t vecs[6];
    FTk_t exp_q[$];
    int   tests  = 0;
    int   failed = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic take_token(input string name);
        FTk_t e;
        if (O_FTk.v) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL %s token: unexpected %0h", name, O_FTk);
            end else begin
                e = exp_q.pop_front();
                check({name, " token"}, 64'(O_FTk), 64'(e));
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input logic [31:0] base);
        logic [31:0] rd_a, last_a, done_a;
        logic [31:0] idx;
        FTk_t        t;
        rd_a   = '0;
        last_a = '0;
        done_a = '0;
        idx    = '0;
        for (int i = 0; i < int'(v.len); i++) begin
            t.v = 1'b1;
            t.d = base + 32'(i);
            exp_q.push_back(t);
        end
        for (int c = 0; c < NCYC; c++) begin
            I_Start       = v.start_m[c];
            I_Len         = v.len;
            I_Src_Valid   = v.valid_m[c];
            I_BTk.n       = v.nack_m[c];
            I_Src_FTk.v   = 1'b0;
            I_Src_FTk.d   = base + idx;
            @(negedge clock);
            rd_a[c]   = O_Src_Rd;
            last_a[c] = O_Last;
            done_a[c] = O_Done;
            take_token(v.name);
            @(posedge clock);
            #1;
            if (rd_a[c])
                idx++;
        end
        I_Start = 1'b0;
        I_Src_Valid = 1'b0;
        I_BTk.n = 1'b0;
        check({v.name, " rd"}, 64'(rd_a), 64'(v.exp_rd));
        check({v.name, " last"}, 64'(last_a), 64'(v.exp_last));
        check({v.name, " done"}, 64'(done_a), 64'(v.exp_done));
        check({v.name, " sent"}, 64'(O_Sent), 64'(v.exp_sent));
        check({v.name, " busy"}, 64'(O_Busy), 64'(0));
        check({v.name, " left"}, 64'(exp_q.size()), 64'(0));
`ifdef STREAM_SENDER_STALL_CNT_EN
        check({v.name, " stall"}, 64'(O_Stall_Cnt), 64'(v.exp_stall));
`else
        check({v.name, " stall"}, 64'(O_Stall_Cnt), 64'(0));
`endif
        exp_q.delete();
    endtask

    initial begin
        int got;
        vec_t v;
        vecs[0] = '{"len4", 4, 32'h1, '1, 32'h0,
                    32'h1E, 32'h20, 32'h40, 4, 0};
        vecs[1] = '{"nack", 8, 32'h1, '1, 32'h38,
                    32'h3F06, 32'h4000, 32'h8000, 8, 5};
        vecs[2] = '{"pulse", 4, 32'h1, '1, 32'h14,
                    32'h382, 32'h400, 32'h800, 4, 5};
        vecs[3] = '{"len0", 0, 32'h1, '1, 32'h0,
                    32'h0, 32'h0, 32'h4, 0, 0};
        vecs[4] = '{"toggle", 3, 32'h5, 32'hAAAA_AAAA, 32'h0,
                    32'h2A, 32'h40, 32'h80, 3, 0};
        vecs[5] = '{"late", 2, 32'h1, 32'hFFFF_FFF8, 32'h0,
                    32'h18, 32'h20, 32'h40, 2, 0};

        reset       = 1'b1;
        I_Start     = 1'b0;
        I_Len       = '0;
        I_Src_Valid = 1'b0;
        I_Src_FTk   = '0;
        I_BTk       = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst ftk", 64'(O_FTk), 64'(0));
        check("rst busy", 64'(O_Busy), 64'(0));
        check("rst done", 64'(O_Done), 64'(0));
        check("rst last", 64'(O_Last), 64'(0));
        check("rst sent", 64'(O_Sent), 64'(0));
        check("rst stall", 64'(O_Stall_Cnt), 64'(0));
        @(posedge clock);
        #1;

        for (int i = 0; i < 6; i++)
            run_vec(vecs[i], 32'(i) * 32'h100);

        // Abort a 10-token burst after three tokens have left
        got = 0;
        for (int i = 0; i < 10; i++)
            exp_q.push_back('{v: 1'b1, d: 32'h900 + 32'(i)});
        I_Len       = 16'd10;
        I_Src_Valid = 1'b1;
        I_BTk.n     = 1'b0;
        for (int c = 0; c < 5; c++) begin
            I_Start     = (c == 0);
            reset       = (c == 4);
            I_Src_FTk.d = 32'h900 + 32'((c > 0) ? c - 1 : 0);
            @(negedge clock);
            if (O_FTk.v)
                got++;
            take_token("abort");
            @(posedge clock);
            #1;
        end
        check("abort pre", 64'(got), 64'(3));
        @(negedge clock);
        check("abort ftk", 64'(O_FTk), 64'(0));
        check("abort busy", 64'(O_Busy), 64'(0));
        check("abort sent", 64'(O_Sent), 64'(0));
        check("abort done", 64'(O_Done), 64'(0));
        @(posedge clock);
        #1;
        reset       = 1'b0;
        I_Src_Valid = 1'b0;
        exp_q.delete();

        v = '{"after", 2, 32'h1, '1, 32'h0,
              32'h6, 32'h8, 32'h10, 2, 0};
        run_vec(v, 32'hA00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
